// File: rtl/ldm_stm_pkg.sv
// Shared types and constants for the LDM/STM address sequencer.
// Holds the FSM state encoding, the {P,U} addressing-mode encoding and sizing defaults.
package ldm_stm_pkg;

    localparam int WORD_BYTES = 4;
    localparam int LIST_W_DEF = 16;
    localparam int ADDR_W_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_XFER = 2'b10,
        S_DONE = 2'b11
    } state_t;

    // Encoded as {P, U}
    typedef enum logic [1:0] {
        MODE_DA = 2'b00,
        MODE_IA = 2'b01,
        MODE_DB = 2'b10,
        MODE_IB = 2'b11
    } addr_mode_t;

endpackage

// File: rtl/reg_list_popcount.sv
// Combinational population count of an LDM/STM register list.
// Zero latency; no flow control.
module reg_list_popcount
    import ldm_stm_pkg::*;
#(
    parameter int W     = LIST_W_DEF,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     reg_list,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CNT_W'(reg_list[i]);
        end
    end

endmodule

// File: rtl/ldm_stm_addr_sequencer.sv
// Walks a latched LDM/STM register list, one (register, word address) pair per cycle, then emits Rn writeback.
// Optional build macro LDM_STM_ALIGN_CHECK_EN: unaligned base aborts with align_fault_out instead of being masked.
module ldm_stm_addr_sequencer
    import ldm_stm_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LIST_W = LIST_W_DEF
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              ldm_stm_start_in,
    input  logic [LIST_W-1:0] reg_list_in,
    input  logic [ADDR_W-1:0] base_addr_in,
    input  logic              pre_index_in,
    input  logic              up_in,
    input  logic              writeback_in,
    input  logic              load_in,
    input  logic              stall_in,
`ifdef LDM_STM_ALIGN_CHECK_EN
    output logic              align_fault_out,
`endif
    output logic [3:0]        reg_addr_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic              xfer_valid_out,
    output logic              load_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              wb_en_out,
    output logic [ADDR_W-1:0] wb_data_out
);

    localparam int CNT_W = $clog2(LIST_W + 1);

    state_t            state;
    logic [LIST_W-1:0] list_q;
    logic [ADDR_W-1:0] base_q;
    logic              pre_q;
    logic              up_q;
    logic              wb_q;

    logic [CNT_W-1:0]  n;
    logic [ADDR_W-1:0] n_bytes;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] wb_val;
    logic [LIST_W-1:0] list_rest;
    logic [3:0]        first_idx;
    logic [3:0]        next_idx;
    logic              align_bad;

    function automatic logic [3:0] lowest_set(input logic [LIST_W-1:0] v);
        lowest_set = '0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = 4'(i);
        end
    endfunction

    reg_list_popcount #(.W(LIST_W), .CNT_W(CNT_W)) u_popcount (
        .reg_list (list_q),
        .count    (n)
    );

    // Lowest register always maps to the lowest address, so descending modes start below base.
    always_comb begin
        n_bytes = ADDR_W'(n) * ADDR_W'(WORD_BYTES);
        case (addr_mode_t'({pre_q, up_q}))
            MODE_IA: start_addr = base_q;
            MODE_IB: start_addr = base_q + ADDR_W'(WORD_BYTES);
            MODE_DA: start_addr = base_q - n_bytes + ADDR_W'(WORD_BYTES);
            default: start_addr = base_q - n_bytes;
        endcase
        wb_val    = up_q ? (base_q + n_bytes) : (base_q - n_bytes);
        list_rest = list_q & (list_q - LIST_W'(1));
        first_idx = lowest_set(list_q);
        next_idx  = lowest_set(list_rest);
`ifdef LDM_STM_ALIGN_CHECK_EN
        align_bad = (base_q[1:0] != 2'b00);
`else
        align_bad = 1'b0;
`endif
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state          <= S_IDLE;
            list_q         <= '0;
            base_q         <= '0;
            pre_q          <= 1'b0;
            up_q           <= 1'b0;
            wb_q           <= 1'b0;
            reg_addr_out   <= '0;
            mem_addr_out   <= '0;
            xfer_valid_out <= 1'b0;
            load_out       <= 1'b0;
            busy_out       <= 1'b0;
            done_out       <= 1'b0;
            wb_en_out      <= 1'b0;
            wb_data_out    <= '0;
`ifdef LDM_STM_ALIGN_CHECK_EN
            align_fault_out <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (ldm_stm_start_in) begin
                        list_q   <= reg_list_in;
`ifdef LDM_STM_ALIGN_CHECK_EN
                        base_q   <= base_addr_in;
`else
                        base_q   <= {base_addr_in[ADDR_W-1:2], 2'b00};
`endif
                        pre_q    <= pre_index_in;
                        up_q     <= up_in;
                        wb_q     <= writeback_in;
                        load_out <= load_in;
                        busy_out <= 1'b1;
                        state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    wb_data_out <= wb_val;
                    if (align_bad || n == '0) begin
                        done_out  <= 1'b1;
                        wb_en_out <= 1'b0;
`ifdef LDM_STM_ALIGN_CHECK_EN
                        align_fault_out <= align_bad;
`endif
                        state     <= S_DONE;
                    end else begin
                        xfer_valid_out <= 1'b1;
                        reg_addr_out   <= first_idx;
                        mem_addr_out   <= start_addr;
                        state          <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (!stall_in) begin
                        list_q <= list_rest;
                        if (list_rest == '0) begin
                            xfer_valid_out <= 1'b0;
                            done_out       <= 1'b1;
                            wb_en_out      <= wb_q;
                            state          <= S_DONE;
                        end else begin
                            reg_addr_out <= next_idx;
                            mem_addr_out <= mem_addr_out + ADDR_W'(WORD_BYTES);
                        end
                    end
                end
                S_DONE: begin
                    done_out  <= 1'b0;
                    wb_en_out <= 1'b0;
                    busy_out  <= 1'b0;
`ifdef LDM_STM_ALIGN_CHECK_EN
                    align_fault_out <= 1'b0;
`endif
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ldm_stm_addr_sequencer.sv
// Directed bench for ldm_stm_addr_sequencer: table of block transfers plus stall, overlap and reset sequences.
// Cycle numbering: cycle 1 is the CALC cycle right after the edge that samples the start pulse.
module tb_ldm_stm_addr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] list;
    logic [31:0] base;
    logic        pre, up, wbk, ld, stall;
    logic [3:0]  reg_addr;
    logic [31:0] mem_addr;
    logic        xfer_valid, load_o, busy, done, wb_en;
    logic [31:0] wb_data;
`ifdef LDM_STM_ALIGN_CHECK_EN
    logic        align_fault;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ldm_stm_addr_sequencer dut (
        .clk_in           (clk),
        .reset_in         (rst),
        .ldm_stm_start_in (start),
        .reg_list_in      (list),
        .base_addr_in     (base),
        .pre_index_in     (pre),
        .up_in            (up),
        .writeback_in     (wbk),
        .load_in          (ld),
        .stall_in         (stall),
`ifdef LDM_STM_ALIGN_CHECK_EN
        .align_fault_out  (align_fault),
`endif
        .reg_addr_out     (reg_addr),
        .mem_addr_out     (mem_addr),
        .xfer_valid_out   (xfer_valid),
        .load_out         (load_o),
        .busy_out         (busy),
        .done_out         (done),
        .wb_en_out        (wb_en),
        .wb_data_out      (wb_data)
    );

    typedef struct {
        string       name;
        logic [15:0] list;
        logic [31:0] base;
        logic        p, u, w, l;
        int          exp_n;
        logic [3:0]  exp_first_reg;
        logic [31:0] exp_first_addr;
        logic [3:0]  exp_last_reg;
        logic [31:0] exp_last_addr;
        int          exp_done;
        logic        exp_wb_en;
        logic [31:0] exp_wb;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic v, input logic [3:0] r, input logic [31:0] a);
        check({name, "_vld"}, 32'(xfer_valid), 32'(v));
        if (v) begin
            check({name, "_reg"}, 32'(reg_addr), 32'(r));
            check({name, "_addr"}, mem_addr, a);
        end
    endtask

    // Pulse start during the low phase; returns at the negedge of cycle 1 with inputs scrambled.
    task automatic launch(input logic [15:0] l, input logic [31:0] b,
                          input logic p, input logic u, input logic w, input logic lb);
        @(negedge clk);
        list = l; base = b; pre = p; up = u; wbk = w; ld = lb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        list = ~l; base = 32'hDEAD_BEE0; pre = ~p; up = ~u; wbk = ~w; ld = ~lb;
    endtask

    task automatic run_vec(input vec_t v);
        int          cyc;
        int          nx;
        logic [3:0]  last_r;
        logic [31:0] last_a;
        bit          seen;
        launch(v.list, v.base, v.p, v.u, v.w, v.l);
        cyc = 1; nx = 0; seen = 0; last_r = '0; last_a = '0;
        check({v.name, "_calc_busy"}, 32'(busy), 32'd1);
        check({v.name, "_calc_vld"}, 32'(xfer_valid), 32'd0);
        check({v.name, "_load"}, 32'(load_o), 32'(v.l));
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (xfer_valid) begin
                if (nx == 0) begin
                    check({v.name, "_first_cyc"}, 32'(cyc), 32'd2);
                    check({v.name, "_first_reg"}, 32'(reg_addr), 32'(v.exp_first_reg));
                    check({v.name, "_first_addr"}, mem_addr, v.exp_first_addr);
                end else begin
                    check({v.name, "_step_order"}, 32'(reg_addr > last_r), 32'd1);
                    check({v.name, "_step_addr"}, mem_addr, last_a + 32'd4);
                end
                check({v.name, "_reg_in_list"}, 32'(v.list[reg_addr]), 32'd1);
                last_r = reg_addr;
                last_a = mem_addr;
                nx++;
            end
            if (done) begin
                seen = 1;
                check({v.name, "_done_cyc"}, 32'(cyc), 32'(v.exp_done));
                check({v.name, "_nxfer"}, 32'(nx), 32'(v.exp_n));
                check({v.name, "_wb_en"}, 32'(wb_en), 32'(v.exp_wb_en));
                if (v.exp_n > 0) begin
                    check({v.name, "_last_reg"}, 32'(last_r), 32'(v.exp_last_reg));
                    check({v.name, "_last_addr"}, last_a, v.exp_last_addr);
                end
                if (v.exp_wb_en) check({v.name, "_wb_data"}, wb_data, v.exp_wb);
`ifdef LDM_STM_ALIGN_CHECK_EN
                check({v.name, "_fault"}, 32'(align_fault), 32'(v.exp_fault));
`endif
            end
        end
        if (!seen) check({v.name, "_done_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        check({v.name, "_idle_busy"}, 32'(busy), 32'd0);
        check({v.name, "_idle_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        vecs[0] = '{"ia", 16'h6721, 32'h1000, 0, 1, 1, 1, 7, 4'd0, 32'h1000, 4'd14, 32'h1018, 9, 1, 32'h101C, 0};
        vecs[1] = '{"ib", 16'h6721, 32'h1000, 1, 1, 1, 0, 7, 4'd0, 32'h1004, 4'd14, 32'h101C, 9, 1, 32'h101C, 0};
        vecs[2] = '{"da", 16'h6721, 32'h1000, 0, 0, 1, 1, 7, 4'd0, 32'h0FE8, 4'd14, 32'h1000, 9, 1, 32'h0FE4, 0};
        vecs[3] = '{"db_nowb", 16'h8001, 32'h1000, 1, 0, 0, 0, 2, 4'd0, 32'h0FF8, 4'd15, 32'h0FFC, 4, 0, 32'h0FF8, 0};
        vecs[4] = '{"empty", 16'h0000, 32'h1000, 0, 1, 1, 1, 0, 4'd0, 32'h0, 4'd0, 32'h0, 2, 0, 32'h0, 0};
        vecs[5] = '{"wrap", 16'hFFFF, 32'hFFFF_FFF0, 0, 1, 1, 1, 16, 4'd0, 32'hFFFF_FFF0, 4'd15, 32'h0000_002C, 18, 1, 32'h0000_0030, 0};
`ifdef LDM_STM_ALIGN_CHECK_EN
        vecs[6] = '{"unaligned", 16'h0003, 32'h1003, 0, 1, 1, 1, 0, 4'd0, 32'h0, 4'd0, 32'h0, 2, 0, 32'h0, 1};
`else
        vecs[6] = '{"unaligned", 16'h0003, 32'h1003, 0, 1, 1, 1, 2, 4'd0, 32'h1000, 4'd1, 32'h1004, 4, 1, 32'h1008, 0};
`endif
        vecs[7] = '{"db_single", 16'h0080, 32'h2000, 1, 0, 1, 0, 1, 4'd7, 32'h1FFC, 4'd7, 32'h1FFC, 3, 1, 32'h1FFC, 0};

        rst = 1'b1; start = 1'b0; list = '0; base = '0;
        pre = 1'b0; up = 1'b0; wbk = 1'b0; ld = 1'b0; stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_vld", 32'(xfer_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wb_en", 32'(wb_en), 32'd0);
        check("rst_reg", 32'(reg_addr), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_load", 32'(load_o), 32'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Stall on the second transfer for two cycles.
        begin
            logic        ev[9];
            logic [3:0]  er[9];
            logic [31:0] ea[9];
            ev = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
            er = '{0, 0, 0, 1, 1, 1, 2, 3, 0};
            ea = '{0, 0, 32'h1000, 32'h1004, 32'h1004, 32'h1004, 32'h1008, 32'h100C, 0};
            launch(16'h000F, 32'h1000, 0, 1, 1, 1);
            for (int c = 1; c <= 8; c++) begin
                check_out($sformatf("stall_c%0d", c), ev[c], er[c], ea[c]);
                check($sformatf("stall_done_c%0d", c), 32'(done), 32'(c == 8));
                if (c == 8) check("stall_wb", wb_data, 32'h1010);
                stall = (c == 3 || c == 4);
                if (c < 8) @(negedge clk);
            end
            stall = 1'b0;
            @(negedge clk);
        end

        // A start pulse while busy must not disturb the running transfer.
        begin
            logic        ev[7];
            logic [3:0]  er[7];
            logic [31:0] ea[7];
            ev = '{0, 0, 1, 1, 1, 0, 0};
            er = '{0, 0, 0, 1, 2, 0, 0};
            ea = '{0, 0, 32'h3000, 32'h3004, 32'h3008, 0, 0};
            launch(16'h0007, 32'h3000, 0, 1, 1, 0);
            for (int c = 1; c <= 6; c++) begin
                check_out($sformatf("ovl_c%0d", c), ev[c], er[c], ea[c]);
                check($sformatf("ovl_done_c%0d", c), 32'(done), 32'(c == 5));
                check($sformatf("ovl_busy_c%0d", c), 32'(busy), 32'(c <= 5));
                if (c == 5) check("ovl_wb", wb_data, 32'h300C);
                if (c == 3) begin
                    start = 1'b1; list = 16'h8000; base = 32'h5000; pre = 1'b1; up = 1'b0;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end

        // Reset in the middle of a transfer, then a fresh start must begin from r0.
        launch(16'h00FF, 32'h4000, 0, 1, 1, 1);
        @(negedge clk);
        check_out("rmid_c2", 1'b1, 4'd0, 32'h4000);
        @(negedge clk);
        check_out("rmid_c3", 1'b1, 4'd1, 32'h4004);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rmid_vld", 32'(xfer_valid), 32'd0);
        check("rmid_busy", 32'(busy), 32'd0);
        check("rmid_done", 32'(done), 32'd0);
        check("rmid_reg", 32'(reg_addr), 32'd0);
        check("rmid_addr", mem_addr, 32'd0);
        check("rmid_wb_data", wb_data, 32'd0);
        check("rmid_load", 32'(load_o), 32'd0);
        run_vec('{"after_rst", 16'h0011, 32'h4000, 0, 1, 1, 1, 2, 4'd0, 32'h4000, 4'd4, 32'h4004, 4, 1, 32'h4008, 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
